// File: rtl/stim_sequencer_if.sv
// Record handshake between the stimulus sequencer and its consumer.
// The sequencer drives valid/pattern/result; the consumer drives ready.
interface stim_sequencer_if #(
  parameter int N_WIDTH = 3
);
  logic               rec_valid;
  logic               rec_ready;
  logic [N_WIDTH-1:0] rec_pattern;
  logic               rec_result;

  modport master (output rec_valid, output rec_pattern, output rec_result, input rec_ready);
  modport slave  (input rec_valid, input rec_pattern, input rec_result, output rec_ready);
endinterface

// File: rtl/stim_sequencer.sv
// Exhaustive stimulus sequencer: walks every N_WIDTH-bit pattern into a DUT,
// waits SETTLE_CYC cycles, samples the single-bit response and offers it as a
// record over a valid/ready handshake. Every output is a flop.
module stim_sequencer #(
  parameter int N_WIDTH    = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic               CK,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic [N_WIDTH-1:0] dut_n,
  input  logic               dut_out,
  stim_sequencer_if.master   rec,
  output logic               busy,
  output logic               done,
  output logic [N_WIDTH:0]   rec_count
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, EMIT, DONE} state_t;

  localparam logic [N_WIDTH-1:0] PAT_MAX   = '1;
  localparam logic [3:0]         SETTLE_LD = 4'(SETTLE_CYC);

  state_t               state_q, state_d;
  logic [N_WIDTH-1:0]   pat_q, pat_d;
  logic [3:0]           settle_q, settle_d;
  logic [N_WIDTH-1:0]   dut_n_q, dut_n_d;
  logic                 rec_valid_q, rec_valid_d;
  logic [N_WIDTH-1:0]   rec_pattern_q, rec_pattern_d;
  logic                 rec_result_q, rec_result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [N_WIDTH:0]     rec_count_q, rec_count_d;

  // State and registered outputs; reset dominates everything.
  always_ff @(posedge CK) begin
    if (reset) begin
      state_q       <= IDLE;
      pat_q         <= '0;
      settle_q      <= '0;
      dut_n_q       <= '0;
      rec_valid_q   <= 1'b0;
      rec_pattern_q <= '0;
      rec_result_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rec_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      settle_q      <= settle_d;
      dut_n_q       <= dut_n_d;
      rec_valid_q   <= rec_valid_d;
      rec_pattern_q <= rec_pattern_d;
      rec_result_q  <= rec_result_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rec_count_q   <= rec_count_d;
    end
  end

  // Next state plus next value of every output flop; abort overrides last.
  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    settle_d      = settle_q;
    dut_n_d       = dut_n_q;
    rec_valid_d   = rec_valid_q;
    rec_pattern_d = rec_pattern_q;
    rec_result_d  = rec_result_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    rec_count_d   = rec_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = APPLY;
          pat_d       = '0;
          rec_count_d = '0;
          dut_n_d     = '0;
          busy_d      = 1'b1;
        end
      end
      APPLY: begin
        state_d  = SETTLE;
        settle_d = SETTLE_LD;
      end
      SETTLE: begin
        // Leave on the last settle cycle so SETTLE lasts exactly SETTLE_CYC.
        if (settle_q <= 4'd1) begin
          state_d  = CAPTURE;
          settle_d = '0;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      CAPTURE: begin
        state_d       = EMIT;
        rec_result_d  = dut_out;
        rec_pattern_d = pat_q;
        rec_valid_d   = 1'b1;
      end
      EMIT: begin
        if (rec.rec_ready) begin
          rec_valid_d = 1'b0;
          rec_count_d = rec_count_q + 1'b1;
          if (pat_q == PAT_MAX) begin
            // Last pattern: no increment, so the pattern never wraps.
            state_d = DONE;
            done_d  = 1'b1;
            dut_n_d = '0;
          end else begin
            state_d = APPLY;
            pat_d   = pat_q + 1'b1;
            dut_n_d = pat_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        dut_n_d     = '0;
        rec_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase

    // Abort wins over a same-cycle handshake: the pending record is dropped.
    if (abort && state_q != IDLE) begin
      state_d       = IDLE;
      pat_d         = pat_q;
      settle_d      = '0;
      dut_n_d       = '0;
      rec_valid_d   = 1'b0;
      rec_pattern_d = rec_pattern_q;
      rec_result_d  = rec_result_q;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      rec_count_d   = rec_count_q;
    end
  end

  assign dut_n           = dut_n_q;
  assign rec.rec_valid   = rec_valid_q;
  assign rec.rec_pattern = rec_pattern_q;
  assign rec.rec_result  = rec_result_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign rec_count       = rec_count_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: instance A uses default parameters with an XOR
// DUT; instance B uses N_WIDTH=1, SETTLE_CYC=1 with a response that toggles
// every cycle. A slot-position model predicts outputs of both each cycle.
module tb_stim_sequencer;
  localparam int NA = 3, SA = 2;
  localparam int NB = 1, SB = 1;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic          reset = 1'b1;
  logic          start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [NA-1:0] dut_n_a;
  logic [NB-1:0] dut_n_b;
  logic          busy_a, done_a, busy_b, done_b, dout_a;
  logic          tog = 1'b0;
  logic [NA:0]   cnt_a;
  logic [NB:0]   cnt_b;

  stim_sequencer_if #(.N_WIDTH(NA)) ifa ();
  stim_sequencer_if #(.N_WIDTH(NB)) ifb ();

  assign dout_a = ^dut_n_a;
  always @(negedge CK) tog = ~tog;

  stim_sequencer #(.N_WIDTH(NA), .SETTLE_CYC(SA)) dut_a (
    .CK(CK), .reset(reset), .start(start_a), .abort(abort_a), .dut_n(dut_n_a),
    .dut_out(dout_a), .rec(ifa), .busy(busy_a), .done(done_a), .rec_count(cnt_a));

  stim_sequencer #(.N_WIDTH(NB), .SETTLE_CYC(SB)) dut_b (
    .CK(CK), .reset(reset), .start(start_b), .abort(abort_b), .dut_n(dut_n_b),
    .dut_out(tog), .rec(ifb), .busy(busy_b), .done(done_b), .rec_count(cnt_b));

  // Model: while a sweep runs, pos counts elapsed slot cycles; each pattern
  // owns SETTLE+3 slots and the final slot of each is the record offer.
  typedef struct {
    bit act;
    bit dn;
    int pos;
    int cnt;
    int rpat;
    bit rres;
  } mdl_t;

  function automatic mdl_t step(mdl_t m, int nw, int sc, bit rst, bit st,
                                bit ab, bit rdy, bit dout);
    mdl_t r;
    int   len, last, ph, pat;
    r    = m;
    len  = sc + 3;
    last = (1 << nw) - 1;
    if (rst) begin
      r.act = 0; r.dn = 0; r.pos = 0; r.cnt = 0; r.rpat = 0; r.rres = 0;
    end else if ((m.act || m.dn) && ab) begin
      r.act = 0; r.dn = 0;
    end else if (m.dn) begin
      r.dn = 0;
    end else if (!m.act) begin
      if (st) begin r.act = 1; r.pos = 0; r.cnt = 0; end
    end else begin
      ph  = m.pos % len;
      pat = m.pos / len;
      if (ph == len - 1) begin
        if (rdy) begin
          r.cnt = m.cnt + 1;
          if (pat == last) begin r.act = 0; r.dn = 1; end
          else r.pos = m.pos + 1;
        end
      end else begin
        if (ph == len - 2) begin r.rpat = pat; r.rres = dout; end
        r.pos = m.pos + 1;
      end
    end
    return r;
  endfunction

  mdl_t ma, mb;
  int   n_chk = 0, n_fail = 0, cyc = 0;
  bit   chk_en = 0;
  logic [NA:0] qa[$];
  logic [NB:0] qb[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance the model and log accepted records on the same edge the DUT sees.
  always @(posedge CK) begin
    cyc++;
    ma = step(ma, NA, SA, reset, start_a, abort_a, ifa.rec_ready, dout_a);
    mb = step(mb, NB, SB, reset, start_b, abort_b, ifb.rec_ready, tog);
    if (reset) chk_en = 1;
    if (!reset && !abort_a && ifa.rec_valid && ifa.rec_ready)
      qa.push_back({ifa.rec_pattern, ifa.rec_result});
    if (!reset && !abort_b && ifb.rec_valid && ifb.rec_ready)
      qb.push_back({ifb.rec_pattern, ifb.rec_result});
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge CK) begin
    if (chk_en) begin
      chk("a.dut_n", int'(dut_n_a), ma.act ? ma.pos / (SA + 3) : 0);
      chk("a.rec_valid", int'(ifa.rec_valid), int'(ma.act && (ma.pos % (SA + 3) == SA + 2)));
      chk("a.rec_pattern", int'(ifa.rec_pattern), ma.rpat);
      chk("a.rec_result", int'(ifa.rec_result), int'(ma.rres));
      chk("a.busy", int'(busy_a), int'(ma.act || ma.dn));
      chk("a.done", int'(done_a), int'(ma.dn));
      chk("a.rec_count", int'(cnt_a), ma.cnt);
      chk("b.dut_n", int'(dut_n_b), mb.act ? mb.pos / (SB + 3) : 0);
      chk("b.rec_valid", int'(ifb.rec_valid), int'(mb.act && (mb.pos % (SB + 3) == SB + 2)));
      chk("b.rec_pattern", int'(ifb.rec_pattern), mb.rpat);
      chk("b.rec_result", int'(ifb.rec_result), int'(mb.rres));
      chk("b.busy", int'(busy_b), int'(mb.act || mb.dn));
      chk("b.done", int'(done_b), int'(mb.dn));
      chk("b.rec_count", int'(cnt_b), mb.cnt);
    end
  end

  // One full sweep on A with an optional ready stall at stall_pat; also pokes
  // start mid-sweep and in the DONE cycle. dur = cycles from start to done.
  task automatic sweep_a(input int stall_pat, input int stall_len, output int dur);
    int t0, left;
    bit stalled;
    qa.delete();
    stalled = 0;
    left    = 0;
    dur     = -1;
    @(negedge CK); start_a = 1'b1; t0 = cyc + 1;
    @(negedge CK); start_a = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done_a) begin dur = cyc - t0; break; end
      start_a = (i == 10);
      if (!stalled && stall_len > 0 && ifa.rec_valid && int'(ifa.rec_pattern) == stall_pat) begin
        ifa.rec_ready = 1'b0;
        left          = stall_len;
        stalled       = 1;
      end else if (left > 0) begin
        left--;
        if (left == 0) ifa.rec_ready = 1'b1;
      end
      @(negedge CK);
    end
    start_a = 1'b1;
    @(negedge CK); start_a = 1'b0;
    @(negedge CK);
    chk("a.idle_after_done", int'(busy_a), 0);
  endtask

  task automatic check_records_a();
    int xr[8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    logic [NA:0] e;
    chk("a.num_records", qa.size(), 8);
    for (int k = 0; k < qa.size() && k < 8; k++) begin
      e = qa[k];
      chk("a.rec_seq_pattern", int'(e[NA:1]), k);
      chk("a.rec_seq_result", int'(e[0]), xr[k]);
    end
    chk("a.final_count", int'(cnt_a), 8);
  endtask

  initial begin
    int  dur;
    bit  hit, saw;
    ifa.rec_ready = 1'b1;
    ifb.rec_ready = 1'b1;
    repeat (2) @(negedge CK);
    reset = 1'b0;
    @(negedge CK);
    chk("reset.busy", int'(busy_a), 0);
    chk("reset.count", int'(cnt_a), 0);
    chk("reset.dut_n", int'(dut_n_a), 0);

    // Plain sweep: 8 records, XOR results, done 40 cycles after start.
    sweep_a(-1, 0, dur);
    chk("a.sweep_cycles", dur, 40);
    check_records_a();

    // Five-cycle ready stall on pattern 3.
    sweep_a(3, 5, dur);
    chk("a.stall_sweep_cycles", dur, 45);
    check_records_a();

    // Abort during SETTLE of pattern 5.
    @(negedge CK); start_a = 1'b1;
    @(negedge CK); start_a = 1'b0;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy_a && dut_n_a == 3'd5) begin hit = 1; break; end
      @(negedge CK);
    end
    chk("abort.reached_pattern5", int'(hit), 1);
    @(negedge CK); abort_a = 1'b1;
    @(negedge CK); abort_a = 1'b0;
    chk("abort.busy", int'(busy_a), 0);
    chk("abort.dut_n", int'(dut_n_a), 0);
    chk("abort.rec_valid", int'(ifa.rec_valid), 0);
    chk("abort.rec_count", int'(cnt_a), 5);
    saw = 0;
    repeat (6) begin @(negedge CK); if (done_a) saw = 1; end
    chk("abort.no_done", int'(saw), 0);

    // Reset while offering the pattern-2 record, with ready high.
    @(negedge CK); start_a = 1'b1;
    @(negedge CK); start_a = 1'b0;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      if (ifa.rec_valid && ifa.rec_pattern == 3'd2) begin hit = 1; break; end
      @(negedge CK);
    end
    chk("rst.reached_emit2", int'(hit), 1);
    reset = 1'b1;
    @(negedge CK); reset = 1'b0;
    chk("rst.dut_n", int'(dut_n_a), 0);
    chk("rst.rec_valid", int'(ifa.rec_valid), 0);
    chk("rst.rec_pattern", int'(ifa.rec_pattern), 0);
    chk("rst.rec_result", int'(ifa.rec_result), 0);
    chk("rst.busy", int'(busy_a), 0);
    chk("rst.done", int'(done_a), 0);
    chk("rst.rec_count", int'(cnt_a), 0);
    sweep_a(-1, 0, dur);
    chk("a.post_reset_sweep_cycles", dur, 40);
    check_records_a();

    // Instance B: 1-bit sweep, 4 cycles per pattern, exactly two records.
    qb.delete();
    dur = -1;
    @(negedge CK); start_b = 1'b1; hit = 0;
    begin
      int t0;
      t0 = cyc + 1;
      @(negedge CK); start_b = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (done_b) begin dur = cyc - t0; break; end
        @(negedge CK);
      end
    end
    chk("b.sweep_cycles", dur, 8);
    start_b = 1'b1;
    @(negedge CK); start_b = 1'b0;
    repeat (3) @(negedge CK);
    chk("b.num_records", qb.size(), 2);
    for (int k = 0; k < qb.size() && k < 2; k++) begin
      logic [NB:0] e;
      e = qb[k];
      chk("b.rec_seq_pattern", int'(e[NB:1]), k);
    end
    chk("b.final_count", int'(cnt_b), 2);
    chk("b.idle", int'(busy_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
